// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor for IEEE-style words with
// configurable exponent/fraction widths: align, add+normalise, round+pack.
module fp_addsub_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic                 op_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_sum,
  output logic [1:0]           out_exc
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 5;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_UNF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Zeros above the hidden-bit position; carry bits are handled separately.
  function automatic int lead_zeros(input logic [M-1:0] v);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    for (int i = M - 3; i >= 0; i--) begin
      if (v[i]) hit = 1'b1;
      else if (!hit) n = n + 1;
    end
    return n;
  endfunction

  function automatic logic [MAN_W+1:0] round_away(input logic [M-1:0] m);
    return {1'b0, m[M-3:2]} + {{(MAN_W+1){1'b0}}, m[1]};
  endfunction

  function automatic logic [W+1:0] saturate(input logic sign,
                                            input logic signed [XW-1:0] exp_n,
                                            input logic signed [XW-1:0] exp_r,
                                            input logic [MAN_W-1:0] frac);
    if (exp_n[XW-1] || exp_n == '0) return {EXC_UNF, {W{1'b0}}};
    if (exp_r >= EXP_MAX) return {EXC_OVF, sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    return {EXC_NONE, sign, exp_r[EXP_W-1:0], frac};
  endfunction

  logic advance;
  logic vld_p0, vld_p1, vld_p2;

  assign advance  = !vld_p2 || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (advance) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // ---- S1: unpack, special cases, magnitude compare, align ----
  logic             sgn_a, sgn_b, a_big, sgn_big;
  logic [EXP_W-1:0] exp_a, exp_b, exp_big, exp_sml, exp_dif;
  logic [MAN_W-1:0] frc_a, frc_b, frc_big, frc_sml;
  logic             nan_a, nan_b, inf_a, inf_b, zro_a, zro_b;
  logic             spec_s1;
  logic [W-1:0]     res_s1;
  logic [1:0]       exc_s1;
  logic [M-1:0]     man_big_s1, man_sml_s1;

  assign sgn_a = in_a[W-1];
  assign sgn_b = in_b[W-1] ^ op_sub;
  assign exp_a = in_a[W-2:MAN_W];
  assign exp_b = in_b[W-2:MAN_W];
  assign frc_a = in_a[MAN_W-1:0];
  assign frc_b = in_b[MAN_W-1:0];
  assign nan_a = (&exp_a) && (frc_a != '0);
  assign nan_b = (&exp_b) && (frc_b != '0);
  assign inf_a = (&exp_a) && (frc_a == '0);
  assign inf_b = (&exp_b) && (frc_b == '0);
  assign zro_a = (exp_a == '0);
  assign zro_b = (exp_b == '0);

  assign a_big   = {exp_a, frc_a} >= {exp_b, frc_b};
  assign sgn_big = a_big ? sgn_a : sgn_b;
  assign exp_big = a_big ? exp_a : exp_b;
  assign exp_sml = a_big ? exp_b : exp_a;
  assign frc_big = a_big ? frc_a : frc_b;
  assign frc_sml = a_big ? frc_b : frc_a;
  assign exp_dif = exp_big - exp_sml;

  assign man_big_s1 = {3'b001, frc_big, 2'b00};
  assign man_sml_s1 = {3'b001, frc_sml, 2'b00} >> exp_dif;

  always_comb begin
    spec_s1 = 1'b1;
    res_s1  = '0;
    exc_s1  = EXC_NONE;
    if (nan_a) begin
      res_s1 = in_a;
      exc_s1 = EXC_NAN;
    end else if (nan_b) begin
      res_s1 = in_b;
      exc_s1 = EXC_NAN;
    end else if (inf_a && inf_b && (sgn_a != sgn_b)) begin
      res_s1 = QNAN;
      exc_s1 = EXC_NAN;
    end else if (inf_a) begin
      res_s1 = {sgn_a, exp_a, frc_a};
      exc_s1 = EXC_OVF;
    end else if (inf_b) begin
      res_s1 = {sgn_b, exp_b, frc_b};
      exc_s1 = EXC_OVF;
    end else if (zro_a && zro_b) begin
      res_s1 = '0;
    end else if (zro_a) begin
      res_s1 = {sgn_b, exp_b, frc_b};
    end else if (zro_b) begin
      res_s1 = in_a;
    end else if (int'(exp_dif) > MAN_W + 2) begin
      res_s1 = {sgn_big, exp_big, frc_big};
    end else begin
      spec_s1 = 1'b0;
    end
  end

  logic             spec_p0, sgn_p0, sub_p0;
  logic [W-1:0]     res_p0;
  logic [1:0]       exc_p0;
  logic [EXP_W-1:0] exp_p0;
  logic [M-1:0]     big_p0, sml_p0;

  always_ff @(posedge clk) begin
    if (advance) begin
      spec_p0 <= spec_s1;
      res_p0  <= res_s1;
      exc_p0  <= exc_s1;
      sgn_p0  <= sgn_big;
      sub_p0  <= sgn_a ^ sgn_b;
      exp_p0  <= exp_big;
      big_p0  <= man_big_s1;
      sml_p0  <= man_sml_s1;
    end
  end

  // ---- S2: add/subtract magnitudes, normalise ----
  logic [M-1:0]          sum_s2, man_s2;
  logic signed [XW-1:0]  exp_ext_s2, exp_s2;
  int                    lz_s2;
  logic                  spec_s2;
  logic [W-1:0]          res_s2;
  logic [1:0]            exc_s2;

  assign exp_ext_s2 = $signed({2'b00, exp_p0});

  always_comb begin
    sum_s2 = sub_p0 ? (big_p0 - sml_p0) : (big_p0 + sml_p0);
    lz_s2  = lead_zeros(sum_s2);
    man_s2 = sum_s2 << lz_s2;
    exp_s2 = exp_ext_s2 - XW'(lz_s2);
    if (sum_s2[M-2]) begin
      man_s2 = sum_s2 >> 1;
      exp_s2 = exp_ext_s2 + XW'(1);
    end
    spec_s2 = spec_p0;
    res_s2  = res_p0;
    exc_s2  = exc_p0;
    if (!spec_p0 && sum_s2 == '0) begin
      spec_s2 = 1'b1;
      res_s2  = '0;
      exc_s2  = EXC_NONE;
    end
  end

  logic                  spec_p1, sgn_p1;
  logic [W-1:0]          res_p1;
  logic [1:0]            exc_p1;
  logic signed [XW-1:0]  exp_p1;
  logic [M-1:0]          man_p1;

  always_ff @(posedge clk) begin
    if (advance) begin
      spec_p1 <= spec_s2;
      res_p1  <= res_s2;
      exc_p1  <= exc_s2;
      sgn_p1  <= sgn_p0;
      exp_p1  <= exp_s2;
      man_p1  <= man_s2;
    end
  end

  // ---- S3: round, renormalise on carry, saturate and pack ----
  logic [MAN_W+1:0]      rnd_s3;
  logic signed [XW-1:0]  exp_r_s3;
  logic [MAN_W-1:0]      frc_s3;
  logic [W+1:0]          pk_s3;

  always_comb begin
    rnd_s3   = round_away(man_p1);
    exp_r_s3 = exp_p1;
    frc_s3   = rnd_s3[MAN_W-1:0];
    if (rnd_s3[MAN_W+1]) begin
      exp_r_s3 = exp_p1 + XW'(1);
      frc_s3   = rnd_s3[MAN_W:1];
    end
    pk_s3 = saturate(sgn_p1, exp_p1, exp_r_s3, frc_s3);
    if (spec_p1) pk_s3 = {exc_p1, res_p1};
  end

  logic [W-1:0] res_p2;
  logic [1:0]   exc_p2;

  always_ff @(posedge clk) begin
    if (advance) begin
      res_p2 <= pk_s3[W-1:0];
      exc_p2 <= pk_s3[W+1:W];
    end
  end

  assign out_valid = vld_p2;
  assign out_sum   = vld_p2 ? res_p2 : '0;
  assign out_exc   = vld_p2 ? exc_p2 : EXC_NONE;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed-vector bench for fp_addsub_pipe: half-precision table, backpressure,
// mid-flight reset and a single-precision instance.
module tb_fp_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [15:0] in_a, in_b, out_sum;
  logic [1:0]  out_exc;

  logic        v32, r32, sub32, ov32, ordy32;
  logic [31:0] a32, b32, sum32;
  logic [1:0]  exc32;

  fp_addsub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_exc(out_exc)
  );

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32),
    .in_a(a32), .in_b(b32), .op_sub(sub32), .out_valid(ov32),
    .out_ready(ordy32), .out_sum(sum32), .out_exc(exc32)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic [1:0]  exc;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_one(input string name, input vec_t v);
    int lat;
    @(negedge clk);
    in_a = v.a; in_b = v.b; op_sub = v.sub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check($sformatf("%s_latency", name), 64'(lat), 64'd3);
    check(name, {out_valid, out_exc, out_sum}, {1'b1, v.exc, v.sum});
  endtask

  task automatic run32(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] exp_sum);
    int lat;
    @(negedge clk);
    a32 = a; b32 = b; sub32 = sub; v32 = 1'b1; ordy32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v32 = 1'b0;
    lat = 1;
    while (!ov32 && lat < 12) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check(name, {ov32, exc32, sum32}, {1'b1, 2'b00, exp_sum});
  endtask

  int   sent, got, stale;
  logic acc;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; op_sub = 1'b0; out_ready = 1'b0;
    v32 = 1'b0; a32 = '0; b32 = '0; sub32 = 1'b0; ordy32 = 1'b0;

    tbl[ 0] = '{16'h5246, 16'h53B4, 1'b0, 16'h56FD, 2'b00};
    tbl[ 1] = '{16'h5246, 16'h53B4, 1'b1, 16'hC9B8, 2'b00};
    tbl[ 2] = '{16'hC900, 16'h4900, 1'b0, 16'h0000, 2'b00};
    tbl[ 3] = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 2'b01};
    tbl[ 4] = '{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 2'b11};
    tbl[ 5] = '{16'h7C01, 16'h3C00, 1'b0, 16'h7C01, 2'b11};
    tbl[ 6] = '{16'h3C00, 16'h7E05, 1'b0, 16'h7E05, 2'b11};
    tbl[ 7] = '{16'h7C00, 16'h7C00, 1'b0, 16'h7C00, 2'b01};
    tbl[ 8] = '{16'h3C00, 16'hFC00, 1'b0, 16'hFC00, 2'b01};
    tbl[ 9] = '{16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 2'b01};
    tbl[10] = '{16'h0000, 16'h4500, 1'b0, 16'h4500, 2'b00};
    tbl[11] = '{16'h4500, 16'h8000, 1'b0, 16'h4500, 2'b00};
    tbl[12] = '{16'h0000, 16'h4500, 1'b1, 16'hC500, 2'b00};
    tbl[13] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 2'b00};
    tbl[14] = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 2'b00};
    tbl[15] = '{16'h7000, 16'h3C00, 1'b0, 16'h7000, 2'b00};
    tbl[16] = '{16'h3C00, 16'h7000, 1'b1, 16'hF000, 2'b00};
    tbl[17] = '{16'h3C00, 16'h1000, 1'b0, 16'h3C01, 2'b00};
    tbl[18] = '{16'h3FFF, 16'h1000, 1'b0, 16'h4000, 2'b00};
    tbl[19] = '{16'h0401, 16'h0400, 1'b1, 16'h0000, 2'b10};
    tbl[20] = '{16'h7BFF, 16'h5000, 1'b0, 16'h7C00, 2'b01};
    tbl[21] = '{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 2'b00};
    tbl[22] = '{16'hBC00, 16'h4000, 1'b0, 16'h3C00, 2'b00};
    tbl[23] = '{16'h3C00, 16'h3800, 1'b0, 16'h3E00, 2'b00};

    @(negedge clk);
    @(negedge clk);
    check("reset_state", {out_valid, in_ready, out_exc, out_sum}, {1'b0, 1'b1, 2'b00, 16'h0000});
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_one($sformatf("vec%0d", i), tbl[i]);

    // Six back-to-back pairs with the consumer stalled for the first five cycles
    sent = 0;
    got  = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        in_a = tbl[sent].a; in_b = tbl[sent].b; op_sub = tbl[sent].sub;
      end
      #1;
      if (c == 3) check("bp_full_stall", {out_valid, in_ready}, 2'b10);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check($sformatf("bp_res%0d", got), {out_exc, out_sum}, {tbl[got].exc, tbl[got].sum});
        got++;
      end
      @(posedge clk);
      if (acc) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_count", 64'(got), 64'd6);
    repeat (4) @(negedge clk);
    check("bp_no_dup", 64'(out_valid), 64'd0);

    // Reset with three operations in flight
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = tbl[k + 3].a; in_b = tbl[k + 3].b; op_sub = tbl[k + 3].sub;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_flight", {out_valid, in_ready, out_exc, out_sum}, {1'b1, 1'b1, 2'b00, 16'h0000} ^ 35'h4_0000_0000 >> 15);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_no_stale", 64'(stale), 64'd0);
    run_one("post_rst", tbl[0]);

    run32("fp32_one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
    run32("fp32_three_minus_one", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
